// File: rtl/onchip_mem_copy_master_pkg.sv
// Shared definitions for the on-chip memory copy master.
//   state_e    : controller states
//   WORD_BYTES : bytes per bus word; the low address bits below it are forced to zero
//   BE_ALL     : byte-enable pattern driven with every read or write request
package onchip_mem_copy_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'b1111;

endpackage

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master that copies word_count 32-bit words from src_addr to
// dst_addr, one word in flight at a time (read, capture, write, repeat).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; latches addresses and count when it arrives
// RD_REQ  | avm_read asserted at src + 4*i until waitrequest drops
// RD_WAIT | waiting for readdatavalid; captures the word
// WR_REQ  | avm_write asserted at dst + 4*i until waitrequest drops
// DONE    | one-cycle done pulse, then back to IDLE
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   start               : one-cycle request, only honoured in IDLE
//   src_addr, dst_addr  : byte addresses, low two bits ignored
//   word_count          : words to copy (0 completes with no bus traffic)
//   busy, done          : status; busy during the copy, done pulses at the end
//   avm_*               : Avalon-MM master interface
module onchip_mem_copy_master
  import onchip_mem_copy_master_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;

  // Byte offset of the current word; truncation gives modulo-2**ADDR_W wrap.
  logic [ADDR_W-1:0] offset;
  logic              last_word;

  always_comb begin
    offset    = ADDR_W'({idx_q, 2'b00});
    last_word = (idx_q == (cnt_q - CNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr & ALIGN_MASK;
          dst_d   = dst_addr & ALIGN_MASK;
          cnt_d   = word_count;
          idx_d   = '0;
          state_d = (word_count == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Read data is only accepted here; a stray valid elsewhere is dropped.
        if (avm_readdatavalid) begin
          wdata_d = avm_readdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state, so address, request and
  // write data are held unchanged for as long as the slave stalls.
  always_comb begin
    avm_read       = (state_q == RD_REQ);
    avm_write      = (state_q == WR_REQ);
    busy           = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
    done           = (state_q == DONE);
    avm_writedata  = wdata_q;
    avm_byteenable = (avm_read || avm_write) ? BE_ALL : 4'b0000;
    avm_address    = '0;
    if (avm_read)  avm_address = src_q + offset;
    if (avm_write) avm_address = dst_q + offset;
  end

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
module tb_onchip_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] src_addr, dst_addr, word_count;
  logic        busy, done;
  logic [12:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        waitrequest;
  logic [31:0] rdata;
  logic        rdv;

  int total = 0;
  int bad   = 0;

  onchip_mem_copy_master #(.ADDR_W(13), .CNT_W(13)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_byteenable    (avm_byteenable),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (waitrequest),
    .avm_readdata      (rdata),
    .avm_readdatavalid (rdv)
  );

  always #5 clk = ~clk;

  // Slave model: word-addressed memory, read latency 1, programmable stall
  // of stall_len cycles on every request. Shares the master's reset.
  logic [31:0] mem [0:2047];
  logic [3:0]  stall_len = 4'd0;
  logic [3:0]  stall_cnt = 4'd0;
  logic        pl_en = 1'b0;
  logic [10:0] pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign waitrequest = (avm_read || avm_write) && (stall_cnt != stall_len);

  always @(posedge clk) begin
    rdv <= 1'b0;
    if (pl_en) mem[pl_idx] <= pl_data;
    if (reset) begin
      stall_cnt <= '0;
    end else begin
      if ((avm_read || avm_write) && waitrequest) stall_cnt <= stall_cnt + 4'd1;
      else stall_cnt <= '0;
      if (avm_read && !waitrequest) begin
        rdv   <= 1'b1;
        rdata <= mem[avm_address[12:2]];
      end
      if (avm_write && !waitrequest) mem[avm_address[12:2]] <= avm_writedata;
    end
  end

  // Per-transfer observations, owned by the stimulus process.
  logic [12:0] rd_log[$];
  logic [12:0] wr_log[$];
  int rw_both, be_bad, stall_viol, stall_cycles, busy_cnt;

  task automatic preload(input logic [10:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Pulses start and watches the bus until done; cyc = cycles after the
  // start cycle at which done is seen, -1 on timeout.
  task automatic run_xfer(input logic [12:0] s, input logic [12:0] d, input logic [12:0] c,
                          input int repulse_at, output int cyc);
    logic        prev_st, stalled;
    logic [12:0] p_addr;
    logic        p_rd, p_wr;
    logic [31:0] p_wd;
    rd_log.delete(); wr_log.delete();
    rw_both = 0; be_bad = 0; stall_viol = 0; stall_cycles = 0; busy_cnt = 0;
    prev_st = 1'b0; p_addr = '0; p_rd = 1'b0; p_wr = 1'b0; p_wd = '0;
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 3000; n++) begin
      if (n > 1) @(negedge clk);
      start = (n == repulse_at);
      if (start) begin
        src_addr = 13'h0000; dst_addr = 13'h1000; word_count = 13'd1;
      end
      if (avm_read && avm_write) rw_both++;
      if ((avm_read || avm_write) && avm_byteenable !== 4'hF) be_bad++;
      if (!(avm_read || avm_write) && avm_byteenable !== 4'h0) be_bad++;
      if (prev_st && (avm_address !== p_addr || avm_read !== p_rd ||
                      avm_write !== p_wr || avm_writedata !== p_wd)) stall_viol++;
      stalled = (avm_read || avm_write) && waitrequest;
      if (stalled) stall_cycles++;
      if (avm_read && !waitrequest) rd_log.push_back(avm_address);
      if (avm_write && !waitrequest) wr_log.push_back(avm_address);
      if (busy) busy_cnt++;
      prev_st = stalled; p_addr = avm_address; p_rd = avm_read; p_wr = avm_write; p_wd = avm_writedata;
      if (done) begin
        cyc = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if ({avm_read, avm_write} !== 2'b00) begin bad++; $display("FAIL reset_rw: got %b want 00", {avm_read, avm_write}); end
    total++; if (avm_address !== 13'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", avm_address); end
    total++; if (avm_byteenable !== 4'h0) begin bad++; $display("FAIL reset_be: got %h want 0", avm_byteenable); end
    total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", avm_writedata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] exp_w [4];
    exp_w = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    for (int i = 0; i < 4; i++) preload(11'(i), exp_w[i]);
    stall_len = 4'd0;
    run_xfer(13'h000, 13'h100, 13'd4, 0, cyc);
    total++; if (cyc !== 13) begin bad++; $display("FAIL basic_done_cycle: got %0d want 13", cyc); end
    total++; if (busy_cnt !== 12) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 12", busy_cnt); end
    total++; if (rw_both !== 0) begin bad++; $display("FAIL basic_rw_overlap: got %0d want 0", rw_both); end
    total++; if (be_bad !== 0) begin bad++; $display("FAIL basic_byteenable: got %0d bad cycles want 0", be_bad); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[11'h40 + 11'(i)] !== exp_w[i]) begin
        bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, mem[11'h40 + 11'(i)], exp_w[i]);
      end
    end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL basic_done_width: got %b want 00", {done, busy}); end
  endtask

  task automatic test_zero_count();
    int cyc;
    run_xfer(13'h040, 13'h140, 13'd0, 0, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", cyc); end
    total++; if (rd_log.size() + wr_log.size() !== 0) begin bad++; $display("FAIL zero_bus_traffic: got %0d want 0", rd_log.size() + wr_log.size()); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL zero_busy: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_stall();
    int cyc;
    preload(11'h008, 32'h5A5A_0001);
    preload(11'h009, 32'h5A5A_0002);
    stall_len = 4'd5;
    run_xfer(13'h020, 13'h200, 13'd2, 0, cyc);
    stall_len = 4'd0;
    total++; if (cyc !== 27) begin bad++; $display("FAIL stall_done_cycle: got %0d want 27", cyc); end
    total++; if (stall_cycles !== 20) begin bad++; $display("FAIL stall_cycles: got %0d want 20", stall_cycles); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", stall_viol); end
    total++; if (mem[11'h080] !== 32'h5A5A_0001) begin bad++; $display("FAIL stall_data0: got %h want 5a5a0001", mem[11'h080]); end
    total++; if (mem[11'h081] !== 32'h5A5A_0002) begin bad++; $display("FAIL stall_data1: got %h want 5a5a0002", mem[11'h081]); end
  endtask

  task automatic test_wrap();
    int cyc;
    preload(11'h7FF, 32'hB0B0_B0B0);
    run_xfer(13'h1FFC, 13'h300, 13'd2, 0, cyc);
    total++; if (cyc !== 7) begin bad++; $display("FAIL wrap_done_cycle: got %0d want 7", cyc); end
    total++; if (rd_log.size() !== 2) begin bad++; $display("FAIL wrap_read_count: got %0d want 2", rd_log.size()); end
    else begin
      total++; if (rd_log[0] !== 13'h1FFC) begin bad++; $display("FAIL wrap_rd0: got %h want 1ffc", rd_log[0]); end
      total++; if (rd_log[1] !== 13'h0000) begin bad++; $display("FAIL wrap_rd1: got %h want 0000", rd_log[1]); end
    end
    total++; if (wr_log.size() !== 2) begin bad++; $display("FAIL wrap_write_count: got %0d want 2", wr_log.size()); end
    else begin
      total++; if (wr_log[1] !== 13'h0304) begin bad++; $display("FAIL wrap_wr1: got %h want 0304", wr_log[1]); end
    end
    total++; if (mem[11'h0C0] !== 32'hB0B0_B0B0) begin bad++; $display("FAIL wrap_data0: got %h want b0b0b0b0", mem[11'h0C0]); end
    total++; if (mem[11'h0C1] !== 32'hA0A0_0000) begin bad++; $display("FAIL wrap_data1: got %h want a0a00000", mem[11'h0C1]); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit hit;
    logic [31:0] src_w [4];
    src_w = '{32'hC0C0_0000, 32'hC1C1_1111, 32'hC2C2_2222, 32'hC3C3_3333};
    for (int i = 0; i < 4; i++) preload(11'h100 + 11'(i), src_w[i]);
    for (int i = 0; i < 4; i++) preload(11'h140 + 11'(i), 32'hDEAD_BEEF);
    @(negedge clk);
    src_addr = 13'h400; dst_addr = 13'h500; word_count = 13'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (avm_write && avm_address == 13'h504) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL midrst_reach_write: got %0b want 1", hit); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({busy, done, avm_read, avm_write} !== 4'b0000) begin bad++; $display("FAIL midrst_ctrl: got %b want 0000", {busy, done, avm_read, avm_write}); end
    total++; if (avm_address !== 13'h0) begin bad++; $display("FAIL midrst_addr: got %h want 0", avm_address); end
    total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL midrst_wdata: got %h want 0", avm_writedata); end
    total++; if (avm_byteenable !== 4'h0) begin bad++; $display("FAIL midrst_be: got %h want 0", avm_byteenable); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (mem[11'h140] !== 32'hC0C0_0000) begin bad++; $display("FAIL midrst_word0: got %h want c0c00000", mem[11'h140]); end
    total++; if (mem[11'h141] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL midrst_word1_untouched: got %h want deadbeef", mem[11'h141]); end
    run_xfer(13'h400, 13'h500, 13'd4, 0, cyc);
    total++; if (cyc !== 13) begin bad++; $display("FAIL midrst_rerun_cycle: got %0d want 13", cyc); end
    total++; if (mem[11'h141] !== 32'hC1C1_1111) begin bad++; $display("FAIL midrst_rerun_word1: got %h want c1c11111", mem[11'h141]); end
    total++; if (mem[11'h143] !== 32'hC3C3_3333) begin bad++; $display("FAIL midrst_rerun_word3: got %h want c3c33333", mem[11'h143]); end
  endtask

  task automatic test_restart_ignored();
    int cyc;
    preload(11'h180, 32'h1234_5678);
    preload(11'h181, 32'h9ABC_DEF0);
    run_xfer(13'h603, 13'h703, 13'd2, 3, cyc);
    total++; if (cyc !== 7) begin bad++; $display("FAIL restart_done_cycle: got %0d want 7", cyc); end
    total++; if (rd_log.size() !== 2 || wr_log.size() !== 2) begin
      bad++; $display("FAIL restart_op_count: got rd=%0d wr=%0d want 2 2", rd_log.size(), wr_log.size());
    end else begin
      total++; if (rd_log[0] !== 13'h600 || rd_log[1] !== 13'h604) begin bad++; $display("FAIL restart_rd_addr: got %h %h want 0600 0604", rd_log[0], rd_log[1]); end
      total++; if (wr_log[0] !== 13'h700 || wr_log[1] !== 13'h704) begin bad++; $display("FAIL restart_wr_addr: got %h %h want 0700 0704", wr_log[0], wr_log[1]); end
    end
    total++; if (mem[11'h1C1] !== 32'h9ABC_DEF0) begin bad++; $display("FAIL restart_data1: got %h want 9abcdef0", mem[11'h1C1]); end
    repeat (3) @(negedge clk);
    total++; if ({busy, done, avm_read, avm_write} !== 4'b0000) begin bad++; $display("FAIL restart_not_queued: got %b want 0000", {busy, done, avm_read, avm_write}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
